// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   F3_*         RV32I load/store size and sign codes (funct3)
//   MAX_LATENCY  largest response latency the counter is sized for
//   state_e      responder FSM state encoding (IDLE=0, WAIT=1, RESP=2)
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Sub-word lane handling for the data-memory responder (combinational).
// Only instantiated when DMEM_SUBWORD_EN is defined.
// Ports:
//   funct3      in   3   load/store size and sign code
//   addr_lo     in   2   byte offset within the word
//   mem_word    in   32  current contents of the addressed word
//   wdata       in   32  right-aligned store data
//   load_data   out  32  selected lane, sign/zero-extended
//   store_word  out  32  mem_word with the addressed bytes replaced
//   align_err   out  1   misaligned access or reserved funct3
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        align_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic [31:0] wlane;

  always_comb begin
    byte_sel   = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel   = mem_word[{addr_lo[1], 4'b0000} +: 16];
    load_data  = mem_word;
    be         = 4'b1111;
    wlane      = wdata;
    align_err  = 1'b0;
    store_word = mem_word;

    // Unsigned codes used on a store behave as the same-size store.
    case (funct3)
      F3_B: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        be        = 4'b0001 << addr_lo;
        wlane     = {4{wdata[7:0]}};
      end
      F3_BU: begin
        load_data = {24'd0, byte_sel};
        be        = 4'b0001 << addr_lo;
        wlane     = {4{wdata[7:0]}};
      end
      F3_H: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata[15:0]}};
        align_err = addr_lo[0];
      end
      F3_HU: begin
        load_data = {16'd0, half_sel};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata[15:0]}};
        align_err = addr_lo[0];
      end
      F3_W: begin
        align_err = |addr_lo;
      end
      default: begin
        align_err = 1'b1;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      if (be[i]) store_word[8*i +: 8] = wlane[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the MEM-stage load/store interface.
// Accepts one request at a time and answers after LATENCY cycles.
// Optional feature: define DMEM_SUBWORD_EN for byte/halfword accesses;
// otherwise every access is a full word and funct3 is ignored.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; resp_valid is a one-cycle pulse that qualifies
// resp_rdata/resp_err, which otherwise just hold their last value.
// Ports:
//   clock, reset (sync, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_funct3  request side
//   resp_valid, resp_rdata, resp_err                              response side
//   busy        high from the accept edge until resp_valid drops
//   dbg_state   current FSM state
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2    // legal 1..MAX_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output state_e      dbg_state
);

  localparam int unsigned CNT_W = $clog2(MAX_LATENCY + 1);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  // The operation being committed. With LATENCY==1 the commit edge is the
  // accept edge itself, so the live request is used instead of the capture.
  logic               c_we;
  logic [31:0]        c_addr, c_wdata;
  logic [2:0]         c_funct3;
  logic [IDX_W-1:0]   c_idx;
  logic               c_err, range_err, align_err;
  logic [31:0]        old_word, load_data, store_word;
  logic               commit, mem_we;

  always_comb begin
    c_we     = (state_q == IDLE) ? req_we     : we_q;
    c_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    c_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
    c_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
  end

  assign c_idx     = c_addr[IDX_W+1:2];
  // Full 30-bit index compare: any high bit set is out of range, no wrap.
  assign range_err = {2'b00, c_addr[31:2]} >= DEPTH_WORDS;
  assign old_word  = mem_q[c_idx];
  assign c_err     = range_err | align_err;

`ifdef DMEM_SUBWORD_EN
  dmem_lane_align u_lane_align (
    .funct3     (c_funct3),
    .addr_lo    (c_addr[1:0]),
    .mem_word   (old_word),
    .wdata      (c_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .align_err  (align_err)
  );
`else
  logic funct3_unused;
  assign funct3_unused = ^c_funct3;
  assign load_data     = old_word;
  assign store_word    = c_wdata;
  assign align_err     = |c_addr[1:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (commit) begin
      resp_err_d   = c_err;
      resp_rdata_d = (c_we || c_err) ? 32'd0 : load_data;
    end
  end

  assign mem_we = commit & c_we & ~c_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array is not reset, but a reset edge suppresses a pending commit.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem_q[c_idx] <= store_word;
  end

  assign req_ready  = reset & (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: u_dut0 runs LATENCY=2, u_dut1 runs LATENCY=1.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // DUT 0 signals
  logic        req_valid0 = 1'b0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [2:0]  req_funct30 = '0;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [31:0] resp_rdata0;
  logic [1:0]  dbg0;

  // DUT 1 signals
  logic        req_valid1 = 1'b0, req_we1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [2:0]  req_funct31 = '0;
  logic        req_ready1, resp_valid1, resp_err1, busy1;
  logic [31:0] resp_rdata1;
  logic [1:0]  dbg1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut0 (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .busy(busy0), .dbg_state(dbg0)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_funct3(req_funct31),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .busy(busy1), .dbg_state(dbg1)
  );

  // scoreboard: {expected response cycle, err, rdata}
  logic [48:0] exp0_q[$];
  logic [48:0] exp1_q[$];
  logic [48:0] e0, e1;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid0 === 1'b1) begin
      n_cmp++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_unexpected_resp: got resp_valid=1 at cyc=%0d expected none", cyc);
      end else begin
        e0 = exp0_q.pop_front();
        if ({cyc, resp_err0, resp_rdata0} !== e0) begin
          n_fail++;
          $display("FAIL dut0_resp: got cyc=%0d err=%0b rdata=0x%08h expected cyc=%0d err=%0b rdata=0x%08h",
                   cyc, resp_err0, resp_rdata0, e0[48:33], e0[32], e0[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid1 === 1'b1) begin
      n_cmp++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected_resp: got resp_valid=1 at cyc=%0d expected none", cyc);
      end else begin
        e1 = exp1_q.pop_front();
        if ({cyc, resp_err1, resp_rdata1} !== e1) begin
          n_fail++;
          $display("FAIL dut1_resp: got cyc=%0d err=%0b rdata=0x%08h expected cyc=%0d err=%0b rdata=0x%08h",
                   cyc, resp_err1, resp_rdata1, e1[48:33], e1[32], e1[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic issue0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                        input bit expect_resp);
    int n;
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_funct30 = f3;
    n = 0;
    while (!req_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready0) begin
      check("dut0_ready_timeout", {31'd0, req_ready0}, 32'd1);
      req_valid0 = 1'b0;
      return;
    end
    if (expect_resp) exp0_q.push_back({16'(cyc + LAT0), exp_err, exp_rdata});
    @(posedge clk);
    #1 req_valid0 = 1'b0;
  endtask

  task automatic issue1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata; req_funct31 = f3;
    n = 0;
    while (!req_ready1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready1) begin
      check("dut1_ready_timeout", {31'd0, req_ready1}, 32'd1);
      req_valid1 = 1'b0;
      return;
    end
    exp1_q.push_back({16'(cyc + LAT1), exp_err, exp_rdata});
    @(posedge clk);
    #1 req_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || busy0 || busy1) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready0", {31'd0, req_ready0}, 32'd0);
    check("rst_valid0", {31'd0, resp_valid0}, 32'd0);
    check("rst_rdata0", resp_rdata0, 32'd0);
    check("rst_err0",   {31'd0, resp_err0}, 32'd0);
    check("rst_busy0",  {31'd0, busy0}, 32'd0);
    check("rst_state0", {30'd0, dbg0}, 32'd0);
    check("rst_ready1", {31'd0, req_ready1}, 32'd0);
    check("rst_valid1", {31'd0, resp_valid1}, 32'd0);
    check("rst_busy1",  {31'd0, busy1}, 32'd0);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready0", {31'd0, req_ready0}, 32'd1);
    check("idle_ready1", {31'd0, req_ready1}, 32'd1);

    // store then load, latency and busy during WAIT
    issue0(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("wait_busy0",  {31'd0, busy0}, 32'd1);
    check("wait_ready0", {31'd0, req_ready0}, 32'd0);
    check("wait_state0", {30'd0, dbg0}, 32'd1);
    issue0(1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0, 1'b1);

    // errors: misaligned, out of range, high address bits, and memory unchanged
    issue0(1'b0, 32'h12, 32'd0, F3_W, 32'd0, 1'b1, 1'b1);
    issue0(1'b1, 32'h12, 32'h55555555, F3_W, 32'd0, 1'b1, 1'b1);
    issue0(1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0, 1'b1);
    issue0(1'b1, 32'h400, 32'h11112222, F3_W, 32'd0, 1'b1, 1'b1);
    issue0(1'b0, 32'h400, 32'd0, F3_W, 32'd0, 1'b1, 1'b1);
    issue0(1'b1, 32'h8000_0010, 32'h33334444, F3_W, 32'd0, 1'b1, 1'b1);
    issue0(1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0, 1'b1);
    // last legal word
    issue0(1'b1, 32'h3FC, 32'hA5A5_5A5A, F3_W, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h3FC, 32'd0, F3_W, 32'hA5A5_5A5A, 1'b0, 1'b1);

`ifdef DMEM_SUBWORD_EN
    issue0(1'b1, 32'h20, 32'h80FF7F01, F3_W, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h23, 32'd0, F3_B,  32'hFFFFFF80, 1'b0, 1'b1);
    issue0(1'b0, 32'h23, 32'd0, F3_BU, 32'h00000080, 1'b0, 1'b1);
    issue0(1'b0, 32'h22, 32'd0, F3_H,  32'hFFFF80FF, 1'b0, 1'b1);
    issue0(1'b1, 32'h21, 32'h000000AA, F3_B, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h20, 32'd0, F3_W,  32'h80FFAA01, 1'b0, 1'b1);
    issue0(1'b0, 32'h20, 32'd0, F3_HU, 32'h0000AA01, 1'b0, 1'b1);
    issue0(1'b0, 32'h21, 32'd0, F3_H,  32'd0, 1'b1, 1'b1);
    issue0(1'b0, 32'h20, 32'd0, 3'b011, 32'd0, 1'b1, 1'b1);
    issue0(1'b0, 32'h20, 32'd0, 3'b110, 32'd0, 1'b1, 1'b1);
    issue0(1'b1, 32'h22, 32'hFFFF1234, F3_H, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h20, 32'd0, F3_W,  32'h1234AA01, 1'b0, 1'b1);
`else
    issue0(1'b1, 32'h50, 32'h12345678, F3_W, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h50, 32'd0, F3_B, 32'h12345678, 1'b0, 1'b1);
    issue0(1'b1, 32'h54, 32'hCAFEF00D, F3_B, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h54, 32'd0, F3_W, 32'hCAFEF00D, 1'b0, 1'b1);
    issue0(1'b0, 32'h51, 32'd0, F3_B, 32'd0, 1'b1, 1'b1);
`endif

    // LATENCY=1 with req_valid held: accepts every other cycle
    drain();
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h40;
    req_wdata1 = 32'h0BADF00D; req_funct31 = F3_W;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("hold_ready1_%0d", i), {31'd0, req_ready1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (req_ready1) exp1_q.push_back({16'(cyc + LAT1), 1'b0, 32'd0});
    end
    req_valid1 = 1'b0;
    issue1(1'b0, 32'h40, 32'd0, F3_W, 32'h0BADF00D, 1'b0);
    issue1(1'b0, 32'h42, 32'd0, F3_W, 32'd0, 1'b1);

    // reset during WAIT drops a pending store
    issue0(1'b1, 32'h30, 32'h11111111, F3_W, 32'd0, 1'b0, 1'b1);
    issue0(1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0, 1'b1);
    drain();
    issue0(1'b1, 32'h30, 32'h22222222, F3_W, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    issue0(1'b0, 32'h30, 32'd0, F3_W, 32'h11111111, 1'b0, 1'b1);

    drain();
    repeat (4) @(negedge clk);
    check("dut0_queue_empty", exp0_q.size(), 32'd0);
    check("dut1_queue_empty", exp1_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
